// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 FFT family: sizes, complex sample type,
// and the 3-bit bit-reversal used to map pipeline lane order to natural bin order.
package fft8_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned W     = 16;
  localparam int unsigned CW    = 2 * W;

  typedef logic [LOG2N-1:0] bin_t;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  function automatic bin_t bitrev3(input bin_t x);
    return {x[0], x[1], x[2]};
  endfunction

endpackage

// File: rtl/fft8_bank.sv
// 8-entry complex register file: two-lane write (shared enable), one combinational read.
module fft8_bank
  import fft8_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [2:0]    wa1,
  input  logic [2:0]    wa2,
  input  logic [CW-1:0] wd1,
  input  logic [CW-1:0] wd2,
  input  logic [2:0]    ra,
  output logic [CW-1:0] rd
);

  cplx_t mem [N];

  // The two lanes of one beat always address distinct bins, so no write collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa1] <= cplx_t'(wd1);
      mem[wa2] <= cplx_t'(wd2);
    end
  end

  assign rd = CW'(mem[ra]);

endmodule

// File: rtl/fft8_reorder.sv
// Ping-pong reorder buffer: accepts bit-reversed lane pairs from the FFT pipeline and
// emits one complex bin per cycle in natural order 0..7 under valid/ready.
module fft8_reorder
  import fft8_pkg::*;
(
  input  logic         c,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x1r,
  input  logic [W-1:0] x1i,
  input  logic [W-1:0] x2r,
  input  logic [W-1:0] x2i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_i,
  output logic [2:0]   out_idx,
  output logic         out_last
);

  logic [1:0]    wb;
  logic [2:0]    ri;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;

  logic          in_fire;
  logic          out_fire;
  logic          wr_last;
  logic          rd_last;
  logic          we0;
  logic          we1;
  logic [2:0]    wa1;
  logic [2:0]    wa2;
  logic [CW-1:0] wd1;
  logic [CW-1:0] wd2;
  logic [CW-1:0] rd0;
  logic [CW-1:0] rd1;
  cplx_t         rd_sel;

  // Handshake depends on state only, never on in_valid.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_last   = in_fire && (wb == 2'd3);
  assign rd_last   = out_fire && (ri == 3'd7);

  // Beat wb carries bins bitrev(2wb) and bitrev(2wb+1): {0,4},{2,6},{1,5},{3,7}.
  assign wa1 = bitrev3({wb, 1'b0});
  assign wa2 = bitrev3({wb, 1'b1});
  assign wd1 = {x1r, x1i};
  assign wd2 = {x2r, x2i};
  assign we0 = in_fire && !wr_bank;
  assign we1 = in_fire && wr_bank;

  fft8_bank u_bank0 (
    .clk (c),
    .we  (we0),
    .wa1 (wa1),
    .wa2 (wa2),
    .wd1 (wd1),
    .wd2 (wd2),
    .ra  (ri),
    .rd  (rd0)
  );

  fft8_bank u_bank1 (
    .clk (c),
    .we  (we1),
    .wa1 (wa1),
    .wa2 (wa2),
    .wd1 (wd1),
    .wd2 (wd2),
    .ra  (ri),
    .rd  (rd1)
  );

  assign rd_sel   = cplx_t'(rd_bank ? rd1 : rd0);
  assign out_r    = W'(rd_sel.re);
  assign out_i    = W'(rd_sel.im);
  assign out_idx  = ri;
  assign out_last = out_valid && (ri == 3'd7);

  // Fill and drain always target different banks, so both updates can land together.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      wb      <= 2'd0;
      ri      <= 3'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (in_fire)  wb      <= wb + 2'd1;
      if (wr_last)  wr_bank <= ~wr_bank;
      if (out_fire) ri      <= ri + 3'd1;
      if (rd_last)  rd_bank <= ~rd_bank;
      full <= full_nxt;
    end
  end

endmodule

// File: tb/tb_fft8_reorder.sv
// Directed bench for fft8_reorder: natural-order drain, ping-pong overlap, stalls,
// simultaneous fill/drain completion, mid-frame reset and extreme sample values.
module tb_fft8_reorder;

  logic        c = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x1r, x1i, x2r, x2i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r, out_i;
  logic [2:0]  out_idx;
  logic        out_last;

  int tests  = 0;
  int failed = 0;

  int lane1_bin [4] = '{0, 2, 1, 3};
  int lane2_bin [4] = '{4, 6, 5, 7};

  fft8_reorder dut (
    .c         (c),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1r       (x1r),
    .x1i       (x1i),
    .x2r       (x2r),
    .x2i       (x2i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 c = ~c;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

  task automatic step();
    @(posedge c);
    @(negedge c);
  endtask

  task automatic do_reset();
    @(negedge c);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge c);
    rst = 1'b0;
  endtask

  // Bin b of a frame with this base carries re = base + b, im = -b.
  task automatic drive_beat(input int w, input int base);
    in_valid = 1'b1;
    x1r = 16'(base + lane1_bin[w]);
    x1i = 16'(-lane1_bin[w]);
    x2r = 16'(base + lane2_bin[w]);
    x2i = 16'(-lane2_bin[w]);
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x1r = '0; x1i = '0; x2r = '0; x2i = '0;
    @(negedge c);
    obs = {in_ready, out_valid, out_last, out_idx};
    tests++;
    if (obs !== 6'b100000) begin
      failed++;
      $display("FAIL reset_state: got {rdy,vld,last,idx}=%b want 100000", obs);
    end
    rst = 1'b0;
    @(negedge c);
  endtask

  task automatic test_single_frame();
    logic [36:0] obs, exp;
    out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      drive_beat(w, 100);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {out_valid, out_last, out_idx, out_r, out_i};
      exp = {1'b1, 1'(i == 7), 3'(i), 16'(100 + i), 16'(-i)};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL single_frame bin %0d: got %h want %h", i, obs, exp);
      end
      step();
    end
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failed++;
      $display("FAIL single_frame_idle: got {vld,rdy}=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] obs, exp;
    int in_cnt = 0, out_cnt = 0, gaps = 0, cyc = 0;
    bit started = 0, ready_fell = 0;
    int ob, oi;
    do_reset();
    out_ready = 1'b1;
    while (out_cnt < 24 && cyc < 200) begin
      if (in_cnt < 12) drive_beat(in_cnt % 4, 200 + 100 * (in_cnt / 4));
      else in_valid = 1'b0;
      if (out_valid) begin
        started = 1;
        ob = 200 + 100 * (out_cnt / 8);
        oi = out_cnt % 8;
        obs = {out_valid, out_last, out_idx, out_r, out_i};
        exp = {1'b1, 1'(oi == 7), 3'(oi), 16'(ob + oi), 16'(-oi)};
        tests++;
        if (obs !== exp) begin
          failed++;
          $display("FAIL back_to_back beat %0d: got %h want %h", out_cnt, obs, exp);
        end
      end else if (started) begin
        gaps++;
      end
      if (!in_ready && in_cnt == 8 && out_cnt < 8) ready_fell = 1;
      if (in_valid && in_ready) in_cnt++;
      if (out_valid && out_ready) out_cnt++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (out_cnt != 24 || in_cnt != 12) begin
      failed++;
      $display("FAIL back_to_back_count: got out=%0d in=%0d want out=24 in=12", out_cnt, in_cnt);
    end
    tests++;
    if (gaps != 0) begin
      failed++;
      $display("FAIL back_to_back_gaps: got %0d want 0", gaps);
    end
    tests++;
    if (ready_fell != 1) begin
      failed++;
      $display("FAIL back_to_back_backpressure: in_ready low before frame 1 drained got %0d want 1", ready_fell);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL back_to_back_end: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [36:0] obs, exp;
    do_reset();
    for (int w = 0; w < 4; w++) begin
      drive_beat(w, 500);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          obs = {out_valid, out_last, out_idx, out_r, out_i};
          exp = {1'b1, 1'b0, 3'd3, 16'd503, 16'hFFFD};
          tests++;
          if (obs !== exp) begin
            failed++;
            $display("FAIL stall_hold cycle %0d: got %h want %h", s, obs, exp);
          end
          step();
        end
        out_ready = 1'b1;
      end
      obs = {out_valid, out_last, out_idx, out_r, out_i};
      exp = {1'b1, 1'(i == 7), 3'(i), 16'(500 + i), 16'(-i)};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL stall bin %0d: got %h want %h", i, obs, exp);
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL stall_end: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [36:0] obs, exp;
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (n < 4) drive_beat(n, 600);
      else if (n >= 8 && n < 12) drive_beat(n - 8, 700);
      else in_valid = 1'b0;
      if (n < 4) begin
        exp = '0;
        obs = {out_valid, 36'd0};
      end else if (n < 12) begin
        exp = {1'b1, 1'(n == 11), 3'(n - 4), 16'(600 + n - 4), 16'(4 - n)};
        obs = {out_valid, out_last, out_idx, out_r, out_i};
      end else begin
        exp = {1'b1, 1'(n == 19), 3'(n - 12), 16'(700 + n - 12), 16'(12 - n)};
        obs = {out_valid, out_last, out_idx, out_r, out_i};
      end
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL simultaneous cycle %0d: got %h want %h", n, obs, exp);
      end
      if (n == 11 || n == 12) begin
        tests++;
        if (in_ready !== 1'b1) begin
          failed++;
          $display("FAIL simultaneous_in_ready cycle %0d: got %b want 1", n, in_ready);
        end
      end
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL simultaneous_end: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [36:0] obs, exp;
    do_reset();
    for (int w = 0; w < 4; w++) begin
      drive_beat(w, 800);
      step();
    end
    for (int w = 0; w < 2; w++) begin
      drive_beat(w, 850);
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid_pre: got out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready, out_last, out_idx} !== 6'b010000) begin
      failed++;
      $display("FAIL reset_mid_immediate: got {vld,rdy,last,idx}=%b want 010000",
               {out_valid, in_ready, out_last, out_idx});
    end
    @(negedge c);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      drive_beat(w, 900);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {out_valid, out_last, out_idx, out_r, out_i};
      exp = {1'b1, 1'(i == 7), 3'(i), 16'(900 + i), 16'(-i)};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL reset_mid_fresh bin %0d: got %h want %h", i, obs, exp);
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_stale: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_extremes();
    logic [36:0] obs, exp;
    logic [15:0] er, ei;
    do_reset();
    out_ready = 1'b1;
    // Even bins carry re=8000/im=7FFF, odd bins the reverse; each lane sees both.
    for (int w = 0; w < 4; w++) begin
      in_valid = 1'b1;
      x1r = (lane1_bin[w] % 2 == 1) ? 16'h7FFF : 16'h8000;
      x1i = (lane1_bin[w] % 2 == 1) ? 16'h8000 : 16'h7FFF;
      x2r = (lane2_bin[w] % 2 == 1) ? 16'h7FFF : 16'h8000;
      x2i = (lane2_bin[w] % 2 == 1) ? 16'h8000 : 16'h7FFF;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      er  = (i % 2 == 1) ? 16'h7FFF : 16'h8000;
      ei  = (i % 2 == 1) ? 16'h8000 : 16'h7FFF;
      obs = {out_valid, out_last, out_idx, out_r, out_i};
      exp = {1'b1, 1'(i == 7), 3'(i), er, ei};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL extremes bin %0d: got %h want %h", i, obs, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_simultaneous();
    test_reset_mid();
    test_extremes();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fft8_reorder.md
# fft8_reorder

Output reorder buffer for the 8-point radix-2 pipelined FFT processor. It accepts the processor's two-lane, bit-reversed-order result pairs (X1, X2) and emits one complex bin per cycle in natural order 0..7 under a valid/ready handshake. Two frame banks in ping-pong let one frame drain while the next one fills. It sits directly downstream of the FFT processor and upstream of any magnitude or serial-out logic.

## Interface
- W, 16, sample width (signed two's complement, real and imag each)
- c  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input pair present this cycle
- in_ready  out  1  buffer can accept a pair this cycle
- x1r, x1i  in  W  lane-1 bin (real, imag)
- x2r, x2i  in  W  lane-2 bin (real, imag) = lane-1 bin index + 4
- out_valid  out  1  out_r/out_i/out_idx hold a valid bin
- out_ready  in  1  downstream accepts the bin
- out_r, out_i  out  W  bin value
- out_idx  out  3  natural bin index 0..7
- out_last  out  1  high with bin 7

## Operation
- Input beat accepted when in_valid && in_ready. Four beats per frame. Beat counter wb (2 bits) selects bins: wb=0 → {0,4}, 1 → {2,6}, 2 → {1,5}, 3 → {3,7}. Lane 1 is written to bin bitrev3(2·wb) and lane 2 to bin bitrev3(2·wb+1).
- Two banks B0/B1, each 8 complex entries plus a full flag. wr_bank starts at B0. On the accepted beat with wb=3: set full[wr_bank], toggle wr_bank, wb wraps to 0.
- in_ready = !full[wr_bank]. Input stalls only when both banks are full.
- Read side: rd_bank starts at B0, read index ri (3 bits). out_valid = full[rd_bank]. out_r/out_i = bank[rd_bank][ri]. out_idx = ri. out_last = out_valid && ri==7.
- Output beat transferred when out_valid && out_ready: ri increments. On ri==7: clear full[rd_bank], toggle rd_bank, ri wraps to 0.
- Simultaneous final write into one bank and final read from the other in the same cycle: both flag updates take effect, no lost frame.
- Holding rules: while out_valid && !out_ready, out_* stay stable. Input lanes are ignored when in_ready is low.
- Data is passed through unmodified: no scaling, no saturation, full W bits preserved including -2^(W-1).
- Reset (any time, including mid-frame or mid-drain): wb, ri, wr_bank, rd_bank and full[] are cleared, and any partial or undrained frame is discarded. Bank contents are don't-care.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_idx=0. out_r/out_i are don't-care while out_valid=0; the bench must check them only when valid.
- Latency: the last input beat is accepted at edge k, out_valid is high after edge k, and bin 0 is presented in cycle k+1 if the read side is idle.
- Throughput: input 4 beats per frame, output 8 beats per frame. Under continuous out_ready, in_ready duty settles to 50%.
- The output is a mux from storage registers, with no extra pipeline register. The in_ready path depends only on state, never on in_valid.

## Structure
- Shared package fft8_pkg: N=8, LOG2N=3, W default, function bitrev3, and the complex sample typedef {re, im}. The FFT processor and any IFFT variant reuse it.
- One sub-module, fft8_bank: an 8-entry complex register file with a dual-lane write port (two addresses, two data, one enable) and one combinational read port. It is instantiated twice.
- The top level holds the counters, full flags, bank pointers and handshake logic.

## Test plan
- Single frame, out_ready=1. Drive beats with value re = 100 + bin and im = -bin, using lane-pair bins per the table. Required response: out_idx 0..7 appear in consecutive cycles starting the cycle after the 4th beat, with out_r = 100..107, out_i = 0..-7, and out_last only at idx 7.
- Three back-to-back frames, in_valid=1 held, out_ready=1. Required response: in_ready falls after frame 2 fills and before frame 1 drains. Frames emerge in order with no gaps in out_valid once started and no bin lost or duplicated.
- Output stall: hold out_ready=0 for 5 cycles at idx 3. Required response: out_idx stays 3 and the data is stable. After release, 4..7 follow.
- Simultaneous completion: time the last write of frame 2 in the same cycle as the idx-7 read of frame 1. Required response: frame 2 drains immediately next cycle with idx 0 and in_ready = 1.
- Reset mid-frame: after 2 input beats, pulse rst for 1 cycle. Required response: out_valid=0 and in_ready=1 immediately. A fresh 4-beat frame then outputs correctly, with no stale bins.
- Extremes: bins carrying 16'h8000 and 16'h7FFF in both lanes. Required response: the values are output bit-exact.
